// File: rtl/mem_arbiter_rr_pkg.sv
// Shared constants for the memory-port arbiter: FSM encodings, arbitration modes
// and the watchdog counter sizing helper.
package mem_arbiter_rr_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // A disabled watchdog (timeout 0) still gets a 1-bit counter so no port is zero-width.
    function automatic int wd_cnt_width(input int timeout_cyc);
        return (timeout_cyc > 0) ? $clog2(timeout_cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational winner selection: fixed priority (lowest index) or round-robin
// starting just after the last winner. Produces both a one-hot grant and its index.
module rr_picker #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    input  logic                 mode,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = IDX_W'(mode ? ((int'(last) + 1 + i) % NUM_PORTS) : i);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port arbiter onto one shared memory port. The winner's command is latched at grant
// and held on mem_* until mem_ready or the watchdog ends the transaction.
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 128,
    parameter int ARB_MODE    = 1,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic [NUM_PORTS-1:0]          ready,
    output logic [NUM_PORTS-1:0]          err,
    output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
    output logic                          busy,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ready
);

    localparam int   IDX_W   = $clog2(NUM_PORTS);
    localparam int   CNT_W   = wd_cnt_width(TIMEOUT_CYC);
    localparam logic ARB_SEL = (ARB_MODE == 0) ? ARB_FIXED : ARB_RR;

    // Handshake: a requester raises req[p] with its command and holds req until it sees
    // ready[p] (err[p] marks a timed-out completion). mem_req stays high with a stable
    // command until the cycle mem_ready is sampled high; mem_ready is ignored otherwise.
    logic [1:0]           state_q, state_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [IDX_W-1:0]     grant_id_q, grant_id_d;
    logic [NUM_PORTS-1:0] owner_oh_q, owner_oh_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [NUM_PORTS-1:0] ready_q, ready_d;
    logic [NUM_PORTS-1:0] err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_PORTS-1:0] pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 wd_expire;

    rr_picker #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_picker (
        .req       (req),
        .last      (last_q),
        .mode      (ARB_SEL),
        .grant     (pick_oh),
        .grant_idx (pick_idx),
        .valid     (pick_valid)
    );

    assign wd_expire = (TIMEOUT_CYC != 0) && (int'(cnt_q) == TIMEOUT_CYC - 1);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_id_d  = grant_id_q;
        owner_oh_d  = owner_oh_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ready_d     = '0;
        err_d       = '0;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    mem_we_d    = we[pick_idx];
                    mem_addr_d  = addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    mem_wdata_d = wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    grant_id_d  = pick_idx;
                    last_d      = pick_idx;
                    owner_oh_d  = pick_oh;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A completion arriving on the expiry cycle takes precedence over the timeout.
                if (mem_ready) begin
                    rdata_d   = mem_we_q ? '0 : mem_rdata;
                    mem_req_d = 1'b0;
                    ready_d   = owner_oh_q;
                    state_d   = ST_RESP;
                end else if (wd_expire) begin
                    rdata_d   = '0;
                    mem_req_d = 1'b0;
                    ready_d   = owner_oh_q;
                    err_d     = owner_oh_q;
                    state_d   = ST_RESP;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= IDX_W'(NUM_PORTS - 1);
            grant_id_q  <= '0;
            owner_oh_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ready_q     <= '0;
            err_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_id_q  <= grant_id_d;
            owner_oh_q  <= owner_oh_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rdata     = rdata_q;
    assign ready     = ready_q;
    assign err       = err_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q != ST_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a round-robin instance with an 8-cycle watchdog and a
// fixed-priority instance, checked against a response scoreboard and hand sequences.
module tb_mem_arbiter_rr;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int TO = 8;
    localparam int EW = 2*NP + DW;

    typedef struct {
        logic [NP-1:0] req;
        logic [NP-1:0] we;
        int            exp_g;
    } vec_t;

    vec_t vecs[10];

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- round-robin DUT ----------------
    logic [NP-1:0]    req = '0;
    logic [NP-1:0]    we = '0;
    logic [NP*AW-1:0] addr = '0;
    logic [NP*DW-1:0] wdata = '0;
    logic [DW-1:0]    rdata;
    logic [NP-1:0]    ready, err;
    logic [1:0]       grant_id;
    logic             busy, mem_req, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata = '0;
    logic             mem_ready = 1'b0;

    mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .grant_id(grant_id), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // ---------------- fixed-priority DUT ----------------
    logic [NP-1:0] req_f = '0;
    logic [DW-1:0] rdata_f;
    logic [NP-1:0] ready_f, err_f;
    logic [1:0]    grant_id_f;
    logic          busy_f, mem_req_f, mem_we_f;
    logic [AW-1:0] mem_addr_f;
    logic [DW-1:0] mem_wdata_f;
    logic [DW-1:0] mem_rdata_f = 128'h1;
    logic          mem_ready_f = 1'b1;

    mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT_CYC(256)) dut_fixed (
        .clk(clk), .rst(rst), .req(req_f), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_f), .ready(ready_f), .err(err_f), .grant_id(grant_id_f), .busy(busy_f),
        .mem_req(mem_req_f), .mem_we(mem_we_f), .mem_addr(mem_addr_f), .mem_wdata(mem_wdata_f),
        .mem_rdata(mem_rdata_f), .mem_ready(mem_ready_f)
    );

    // ---------------- memory model ----------------
    int            mem_lat = 0;      // negative: never answer
    logic          mem_spur = 1'b0;
    logic          use_fixed = 1'b0;
    logic [DW-1:0] fixed_rd = '0;
    int            wait_cnt = 0;

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1234_5678};
    endfunction

    always @(negedge clk) begin
        if (mem_spur) begin
            mem_ready = 1'b1;
        end else if (mem_req && !mem_ready) begin
            if (mem_lat >= 0 && wait_cnt >= mem_lat) mem_ready = 1'b1;
            else wait_cnt++;
        end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end
        mem_rdata = use_fixed ? fixed_rd : rd_model(mem_addr);
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int tests_run = 0;
    int tests_failed = 0;

    logic [AW-1:0] port_addr[NP];
    logic [DW-1:0] port_wdata[NP];

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int g, input bit e, input logic [DW-1:0] rd);
        logic [NP-1:0] oh;
        oh = NP'(1) << g;
        exp_q.push_back({oh, (e ? oh : {NP{1'b0}}), rd});
    endtask

    // ---------------- driver tasks ----------------
    task automatic pack_ports();
        for (int p = 0; p < NP; p++) begin
            addr[p*AW +: AW]  = port_addr[p];
            wdata[p*DW +: DW] = port_wdata[p];
        end
    endtask

    task automatic randomize_ports();
        for (int p = 0; p < NP; p++) begin
            port_addr[p]  = 32'($urandom_range(32'h00FF_FFFF, 0)) << 4;
            port_wdata[p] = {32'($urandom_range(32'hFFFF_FFFF, 0)), 32'($urandom_range(32'hFFFF_FFFF, 0)),
                             32'($urandom_range(32'hFFFF_FFFF, 0)), 32'($urandom_range(32'hFFFF_FFFF, 0))};
        end
        pack_ports();
    endtask

    task automatic wait_ready(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_ready: no ready pulse within %0d cycles, required one", bound);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required $finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int n, g, prev_cyc, npulse;

        vecs[0] = '{4'b1111, 4'b0000, 0};
        vecs[1] = '{4'b1111, 4'b0000, 1};
        vecs[2] = '{4'b0001, 4'b0000, 0};
        vecs[3] = '{4'b0001, 4'b0000, 0};
        vecs[4] = '{4'b1000, 4'b1000, 3};
        vecs[5] = '{4'b0110, 4'b0000, 1};
        vecs[6] = '{4'b0110, 4'b0000, 2};
        vecs[7] = '{4'b1011, 4'b0000, 3};
        vecs[8] = '{4'b0100, 4'b0100, 2};
        vecs[9] = '{4'b1111, 4'b0000, 3};

        fork
            forever begin
                @(negedge clk);
                if (!rst && (ready != '0 || err != '0)) begin
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL resp_unexpected: got ready=%b err=%b, required no pulse", ready, err);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("resp", {ready, err, rdata}, mon_e);
                    end
                end
            end
        join_none

        // reset state of both instances
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rr", {mem_req, ready, err, grant_id, busy, rdata, mem_we, mem_addr}, '0);
        check("reset_rr_wdata", mem_wdata, '0);
        check("reset_fixed", {mem_req_f, ready_f, err_f, grant_id_f, busy_f, rdata_f, mem_we_f, mem_addr_f}, '0);
        check("reset_fixed_wdata", mem_wdata_f, '0);
        rst = 1'b0;

        // reset while port 1 owns the memory
        mem_lat = -1;
        randomize_ports();
        req = 4'b0010;
        @(negedge clk);
        check("rst_mid_grant", {busy, mem_req, grant_id}, {1'b1, 1'b1, 2'd1});
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_busy", {mem_req, ready, grant_id, busy}, '0);
        @(negedge clk);

        // all ports requesting: rotation from port 0, one pulse every 3 cycles
        mem_lat = 0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = k % NP;
            push_exp(g, 1'b0, rd_model(port_addr[g]));
        end
        rst = 1'b0;
        prev_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ready(10, ok);
            if (ok) begin
                if (k > 0) check("rr_gap", cyc - prev_cyc, 3);
                prev_cyc = cyc;
            end
        end
        req = '0;
        @(negedge clk);

        // table-driven single transactions
        apply_reset();
        mem_lat = 0;
        for (int i = 0; i < 10; i++) begin
            randomize_ports();
            g = vecs[i].exp_g;
            req = vecs[i].req;
            we  = vecs[i].we;
            push_exp(g, 1'b0, vecs[i].we[g] ? {DW{1'b0}} : rd_model(port_addr[g]));
            @(negedge clk);
            check($sformatf("vec%0d_cmd", i), {busy, mem_req, grant_id, mem_we, mem_addr, mem_wdata},
                  {1'b1, 1'b1, 2'(g), vecs[i].we[g], port_addr[g], port_wdata[g]});
            wait_ready(10, ok);
            req = '0;
            we  = '0;
            @(negedge clk);
        end

        // fixed priority: port 1 served repeatedly, port 3 starves
        req_f = 4'b1010;
        npulse = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (busy_f) check("fixed_grant", grant_id_f, 2'd1);
            if (ready_f != '0) begin
                npulse++;
                check("fixed_pulse", {ready_f, rdata_f}, {4'b0010, 128'h1});
            end
        end
        req_f = '0;
        check("fixed_count", npulse, 10);
        repeat (2) @(negedge clk);

        // slow read on port 2; command changes and req drop after grant are ignored
        use_fixed = 1'b1;
        fixed_rd  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
        mem_lat   = 5;
        port_addr[2] = 32'h0000_1000;
        pack_ports();
        we  = '0;
        req = 4'b0100;
        push_exp(2, 1'b0, fixed_rd);
        @(negedge clk);
        check("slow_grant", {busy, grant_id, mem_addr}, {1'b1, 2'd2, 32'h0000_1000});
        port_addr[2]  = 32'h0000_2000;
        port_wdata[2] = ~port_wdata[2];
        pack_ports();
        we  = 4'b0100;
        req = '0;
        n = 0;
        while (mem_req && n < 20) begin
            check("slow_hold", {mem_we, mem_addr}, {1'b0, 32'h0000_1000});
            n++;
            @(negedge clk);
        end
        check("slow_busy_len", n, 6);
        check("slow_ready", ready, 4'b0100);
        @(negedge clk);
        check("slow_one_shot", {ready, err}, '0);
        use_fixed = 1'b0;
        we = '0;

        // watchdog expiry on port 0
        randomize_ports();
        mem_lat = -1;
        req = 4'b0001;
        push_exp(0, 1'b1, {DW{1'b0}});
        @(negedge clk);
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        req = '0;
        check("timeout_busy_len", n, TO);
        check("timeout_resp", {ready, err, rdata}, {4'b0001, 4'b0001, {DW{1'b0}}});
        @(negedge clk);
        check("timeout_one_shot", {ready, err}, '0);

        // completion on the expiry cycle wins over the timeout
        randomize_ports();
        mem_lat = TO - 1;
        req = 4'b0001;
        push_exp(0, 1'b0, rd_model(port_addr[0]));
        @(negedge clk);
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        req = '0;
        check("expiry_busy_len", n, TO);
        check("expiry_resp", {ready, err}, {4'b0001, 4'b0000});
        @(negedge clk);

        // mem_ready while idle must not create a response
        mem_spur = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("spurious_idle", {busy, ready, err}, '0);
        end
        mem_spur = 1'b0;
        repeat (2) @(negedge clk);

        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
